// File: rtl/ycr_core_idle_ctrl.sv
// ycr_core_idle_ctrl: per-core idle/wake sequencer driving the clock-gate
// dst_idle input. Runs on the ungated interface clock. Entry is guarded by a
// drain phase and a programmable settle delay; exit waits for the gate's
// clock-enable acknowledge, with a bounded timeout that flags a sticky error.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | core running, watching for WFI
// DRAIN | WFI seen, waiting for fetch/LSU transactions to drain
// HOLD  | pipeline empty, counting down the settle delay
// IDLE  | core_idle asserted, counting sleep cycles
// WAKE  | interrupt seen, waiting for gate ack (or timeout) before resume
module ycr_core_idle_ctrl #(
  parameter int DLY_W     = 8,
  parameter int WAKE_TO_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_enb,
  input  logic [DLY_W-1:0] cfg_idle_dly,
  input  logic             wfi_req,
  input  logic             pipe_busy,
  input  logic             irq_timer,
  input  logic             irq_ext,
  input  logic             irq_soft,
  input  logic             gate_clk_enb,
  input  logic             cnt_clr,
  output logic             core_idle,
  output logic             wake_pulse,
  output logic             wake_err,
  output logic [2:0]       idle_state,
  output logic [CNT_W-1:0] sleep_cnt
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_HOLD  = 3'd2,
    ST_IDLE  = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  localparam logic [DLY_W-1:0]     DLY_ZERO = '0;
  localparam logic [DLY_W-1:0]     DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [WAKE_TO_W-1:0] TO_ZERO  = '0;
  localparam logic [WAKE_TO_W-1:0] TO_ONE   = {{(WAKE_TO_W-1){1'b0}}, 1'b1};
  localparam logic [WAKE_TO_W-1:0] TO_MAX   = '1;
  localparam logic [CNT_W-1:0]     CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  state_t               state_q, state_d;
  logic [DLY_W-1:0]     dly_cnt_q, dly_cnt_d;
  logic [WAKE_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]     sleep_cnt_q, sleep_cnt_d;
  logic                 core_idle_q, core_idle_d;
  logic                 wake_pulse_q, wake_pulse_d;
  logic                 wake_err_q, wake_err_d;

  logic irq_any;
  logic abort;
  logic sleep_inc;
  logic err_set;

  assign irq_any = irq_timer | irq_ext | irq_soft;
  // Any reason to give up on idle entry while still in DRAIN/HOLD.
  assign abort   = irq_any | ~wfi_req | ~cfg_enb;

  // Next-state, timer and statistics decode.
  always_comb begin
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    to_cnt_d     = to_cnt_q;
    wake_pulse_d = 1'b0;
    sleep_inc    = 1'b0;
    err_set      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (cfg_enb && wfi_req && !irq_any) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_RUN;
        end else if (!pipe_busy) begin
          if (cfg_idle_dly == DLY_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            dly_cnt_d = cfg_idle_dly;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Delay was latched on entry; later cfg changes are deliberately ignored.
        if (abort || pipe_busy) begin
          state_d = ST_RUN;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_ONE;
          if (dly_cnt_q == DLY_ONE) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // wfi_req is not an exit source: the core is gated and cannot drop it.
        if (irq_any || !cfg_enb) begin
          state_d  = ST_WAKE;
          to_cnt_d = TO_ZERO;
        end else begin
          sleep_inc = 1'b1;
        end
      end
      ST_WAKE: begin
        to_cnt_d = to_cnt_q + TO_ONE;
        if (gate_clk_enb) begin
          wake_pulse_d = 1'b1;
          state_d      = ST_RUN;
        end else if (to_cnt_d == TO_MAX) begin
          // Resume anyway so a dead gate cannot hang the core forever.
          wake_pulse_d = 1'b1;
          err_set      = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    core_idle_d = (state_d == ST_IDLE);

    if (cnt_clr) begin
      sleep_cnt_d = CNT_ZERO;
      wake_err_d  = 1'b0;
    end else begin
      sleep_cnt_d = (sleep_inc && sleep_cnt_q != CNT_MAX) ? sleep_cnt_q + CNT_ONE
                                                          : sleep_cnt_q;
      wake_err_d  = wake_err_q | err_set;
    end
  end

  // State, timers and registered outputs; reset forces core_idle low at once.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      dly_cnt_q    <= DLY_ZERO;
      to_cnt_q     <= TO_ZERO;
      sleep_cnt_q  <= CNT_ZERO;
      core_idle_q  <= 1'b0;
      wake_pulse_q <= 1'b0;
      wake_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      to_cnt_q     <= to_cnt_d;
      sleep_cnt_q  <= sleep_cnt_d;
      core_idle_q  <= core_idle_d;
      wake_pulse_q <= wake_pulse_d;
      wake_err_q   <= wake_err_d;
    end
  end

  assign core_idle  = core_idle_q;
  assign wake_pulse = wake_pulse_q;
  assign wake_err   = wake_err_q;
  assign idle_state = state_q;
  assign sleep_cnt  = sleep_cnt_q;

endmodule

// File: tb/tb_ycr_core_idle_ctrl.sv
// Bench for ycr_core_idle_ctrl: directed scenarios plus random traffic,
// scored against a cycle-level behavioural model of the idle/wake rules.
module tb_ycr_core_idle_ctrl;

  localparam int DLY_W = 8;
  localparam int TO_W  = 4;
  localparam int TO_LIMIT = (1 << TO_W) - 1;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic             cfg_enb = 1'b0;
  logic [DLY_W-1:0] cfg_idle_dly = '0;
  logic             wfi_req = 1'b0;
  logic             pipe_busy = 1'b0;
  logic             irq_timer = 1'b0;
  logic             irq_ext = 1'b0;
  logic             irq_soft = 1'b0;
  logic             gate_clk_enb = 1'b0;
  logic             cnt_clr = 1'b0;

  logic        core_idle, wake_pulse, wake_err;
  logic [2:0]  idle_state;
  logic [15:0] sleep_cnt;
  logic        core_idle4, wake_pulse4, wake_err4;
  logic [2:0]  idle_state4;
  logic [3:0]  sleep_cnt4;

  ycr_core_idle_ctrl #(.DLY_W(DLY_W), .WAKE_TO_W(TO_W), .CNT_W(16)) u_dut (
    .clk_in(clk_in), .reset(reset), .cfg_enb(cfg_enb), .cfg_idle_dly(cfg_idle_dly),
    .wfi_req(wfi_req), .pipe_busy(pipe_busy), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_soft(irq_soft), .gate_clk_enb(gate_clk_enb), .cnt_clr(cnt_clr),
    .core_idle(core_idle), .wake_pulse(wake_pulse), .wake_err(wake_err),
    .idle_state(idle_state), .sleep_cnt(sleep_cnt)
  );

  // Narrow-counter build, used to reach saturation in a few cycles.
  ycr_core_idle_ctrl #(.DLY_W(DLY_W), .WAKE_TO_W(TO_W), .CNT_W(4)) u_dut4 (
    .clk_in(clk_in), .reset(reset), .cfg_enb(cfg_enb), .cfg_idle_dly(cfg_idle_dly),
    .wfi_req(wfi_req), .pipe_busy(pipe_busy), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_soft(irq_soft), .gate_clk_enb(gate_clk_enb), .cnt_clr(cnt_clr),
    .core_idle(core_idle4), .wake_pulse(wake_pulse4), .wake_err(wake_err4),
    .idle_state(idle_state4), .sleep_cnt(sleep_cnt4)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int st;
    bit idle;
    bit pulse;
    bit err;
    int cnt16;
    int cnt4;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: phase 0..4 = run/drain/hold/idle/wake, plus plain counts.
  int m_st, m_hold_len, m_hold_n, m_wake_n, m_sleep;
  bit m_err, m_pulse;

  task automatic model_reset();
    m_st = 0; m_hold_len = 0; m_hold_n = 0; m_wake_n = 0;
    m_sleep = 0; m_err = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    bit irq, leave, counted, err_now;
    exp_t e;
    irq     = irq_timer | irq_ext | irq_soft;
    leave   = irq || !wfi_req || !cfg_enb;
    counted = 1'b0;
    err_now = 1'b0;
    m_pulse = 1'b0;
    case (m_st)
      0: if (cfg_enb && wfi_req && !irq) m_st = 1;
      1: begin
        if (leave) m_st = 0;
        else if (!pipe_busy) begin
          if (cfg_idle_dly == 0) m_st = 3;
          else begin m_hold_len = int'(cfg_idle_dly); m_hold_n = 0; m_st = 2; end
        end
      end
      2: begin
        if (leave || pipe_busy) m_st = 0;
        else begin
          m_hold_n++;
          if (m_hold_n == m_hold_len) m_st = 3;
        end
      end
      3: begin
        if (irq || !cfg_enb) begin m_st = 4; m_wake_n = 0; end
        else counted = 1'b1;
      end
      default: begin
        m_wake_n++;
        if (gate_clk_enb) begin m_pulse = 1'b1; m_st = 0; end
        else if (m_wake_n == TO_LIMIT) begin m_pulse = 1'b1; err_now = 1'b1; m_st = 0; end
      end
    endcase
    if (cnt_clr) begin
      m_sleep = 0; m_err = 1'b0;
    end else begin
      if (counted) m_sleep++;
      if (err_now) m_err = 1'b1;
    end
    e.st    = m_st;
    e.idle  = (m_st == 3);
    e.pulse = m_pulse;
    e.err   = m_err;
    e.cnt16 = (m_sleep > 65535) ? 65535 : m_sleep;
    e.cnt4  = (m_sleep > 15) ? 15 : m_sleep;
    sb_q.push_back(e);
  endtask

  // Apply one cycle of stimulus at the falling edge and queue its expected result.
  task automatic cyc(input bit wfi, input bit busy, input bit [2:0] irq, input bit gate,
                     input bit enb, input bit clr, input int dly);
    @(negedge clk_in);
    reset        = 1'b0;
    wfi_req      = wfi;
    pipe_busy    = busy;
    irq_timer    = irq[0];
    irq_ext      = irq[1];
    irq_soft     = irq[2];
    gate_clk_enb = gate;
    cfg_enb      = enb;
    cnt_clr      = clr;
    cfg_idle_dly = DLY_W'(dly);
    model_step();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered result; score it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (int'(idle_state) != e.st || core_idle != e.idle || wake_pulse != e.pulse ||
            wake_err != e.err || int'(sleep_cnt) != e.cnt16 ||
            int'(idle_state4) != e.st || core_idle4 != e.idle || wake_pulse4 != e.pulse ||
            wake_err4 != e.err || int'(sleep_cnt4) != e.cnt4) begin
          n_err++;
          $display("FAIL vec%0d @%0t: got st=%0d idle=%0b pulse=%0b err=%0b cnt=%0d cnt4=%0d st4=%0d | expected st=%0d idle=%0b pulse=%0b err=%0b cnt=%0d cnt4=%0d",
                   n_vec, $time, idle_state, core_idle, wake_pulse, wake_err, sleep_cnt,
                   sleep_cnt4, idle_state4, e.st, e.idle, e.pulse, e.err, e.cnt16, e.cnt4);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_gate, dly_r;
    model_reset();
    wfi_req = 1'b1;
    cfg_enb = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_state", int'(idle_state), 0);
    check("reset_idle", int'(core_idle), 0);
    check("reset_cnt", int'(sleep_cnt), 0);

    // Entry with settle delay 3, 10 counted IDLE cycles, irq, ack two cycles later.
    repeat (15) cyc(1, 0, 3'b000, 0, 1, 0, 3);
    cyc(1, 0, 3'b001, 0, 1, 0, 3);
    cyc(0, 0, 3'b000, 0, 1, 0, 3);
    cyc(0, 0, 3'b000, 1, 1, 0, 3);
    repeat (3) cyc(0, 0, 3'b000, 0, 1, 0, 3);
    check("tp1_sleep_cnt", int'(sleep_cnt), 10);

    // Busy drain then irq in second HOLD cycle: abort, no idle, no count.
    repeat (6) cyc(1, 1, 3'b000, 0, 1, 0, 4);
    cyc(1, 0, 3'b000, 0, 1, 0, 4);
    cyc(1, 0, 3'b000, 0, 1, 0, 4);
    cyc(1, 0, 3'b010, 0, 1, 0, 4);
    repeat (2) cyc(0, 0, 3'b000, 0, 1, 0, 4);
    check("tp3_sleep_cnt", int'(sleep_cnt), 10);

    // Zero delay: straight from DRAIN to IDLE; then cfg_enb low ignores WFI.
    repeat (3) cyc(1, 0, 3'b000, 0, 1, 0, 0);
    cyc(0, 0, 3'b100, 0, 1, 0, 0);
    cyc(0, 0, 3'b000, 1, 1, 0, 0);
    repeat (4) cyc(1, 0, 3'b000, 0, 0, 0, 0);
    check("enb_off_state", int'(idle_state), 0);

    // Gate ack never arrives: timeout pulse and sticky error, then clear.
    repeat (4) cyc(1, 0, 3'b000, 0, 1, 0, 0);
    cyc(1, 0, 3'b001, 0, 1, 0, 0);
    repeat (18) cyc(0, 0, 3'b000, 0, 1, 0, 0);
    check("timeout_err", int'(wake_err), 1);
    cyc(0, 0, 3'b000, 0, 1, 1, 0);
    cyc(0, 0, 3'b000, 0, 1, 0, 0);
    check("clr_err", int'(wake_err), 0);
    check("clr_cnt", int'(sleep_cnt), 0);

    // Long IDLE saturates the narrow counter; reset mid-IDLE drops idle at once.
    repeat (24) cyc(1, 0, 3'b000, 0, 1, 0, 0);
    check("sat_cnt4", int'(sleep_cnt4), 15);
    @(negedge clk_in);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_idle", int'(core_idle), 0);
    check("async_rst_state", int'(idle_state), 0);
    check("async_rst_cnt", int'(sleep_cnt), 0);

    // Random traffic in segments with varying gate-ack behaviour.
    dly_r = 2;
    for (int seg = 0; seg < 60; seg++) begin
      p_gate = int'($urandom_range(0, 3));
      for (int k = 0; k < 50; k++) begin
        if ($urandom % 32 == 0) dly_r = int'($urandom_range(0, 6));
        cyc(($urandom % 8) != 0, ($urandom % 3) == 0,
            {($urandom % 24) == 0, ($urandom % 24) == 0, ($urandom % 24) == 0},
            (p_gate != 0) && (int'($urandom % 4) < p_gate),
            ($urandom % 16) != 0, ($urandom % 64) == 0, dly_r);
      end
    end

    @(posedge clk_in);
    #2;
    check("queue_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
